// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the 8x8 red/green dot-matrix display path. Used by
// the frame writer (producer side) and the Matrix row scanner (consumer side).
//
// Contents:
//   op_e      command op codes carried on opI
//   state_e   frame-writer FSM states (also exported on the debug state port)
//   C_*       2-bit pixel colours, bit1 = red, bit0 = green
//   FRAME_W   width of the packed frame vector
//   pix_lsb() bit index of the low bit of pixel (row,col) in a frame vector
// -----------------------------------------------------------------------------
package matrix_pkg;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_TOGGLE = 2'b01,
      OP_FILL   = 2'b10,
      OP_SWAP   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE      = 2'b00,
      S_FILL      = 2'b01,
      S_SWAP_WAIT = 2'b10
   } state_e;

   localparam logic [1:0] C_OFF   = 2'b00;
   localparam logic [1:0] C_GREEN = 2'b01;
   localparam logic [1:0] C_RED   = 2'b10;
   localparam logic [1:0] C_AMBER = 2'b11;

   localparam int FRAME_W = 128;

   // Pixel p = row*8+col sits at bits [127-2p : 126-2p], so its low bit is
   // 126-2p. {row,col,1'b0} is exactly 2p in 7 bits.
   function automatic logic [6:0] pix_lsb(input logic [2:0] row,
                                          input logic [2:0] col);
      return 7'd126 - {row, col, 1'b0};
   endfunction

endpackage

// File: rtl/matrix_bank.sv
// -----------------------------------------------------------------------------
// matrix_bank
// 128-bit back buffer of the dot-matrix frame writer. One pixel
// read-modify-write port (plain write or XOR toggle) and one 16-bit row-write
// port. The two ports are never active in the same cycle in normal use; if
// they were, the row write takes priority.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (clears buffer)
//   pix_we_i         write one pixel this cycle
//   pix_toggle_i     1: XOR pix_color_i into the pixel, 0: overwrite it
//   pix_row_i/col_i  pixel coordinates
//   pix_color_i      2-bit colour operand
//   row_we_i         write a full row this cycle
//   row_sel_i        row index for the row write
//   row_data_i       16 bits, leftmost pixel in the top two bits
//   data_o           current buffer contents, frame vector layout
// -----------------------------------------------------------------------------
module matrix_bank
   import matrix_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               pix_we_i,
   input  logic               pix_toggle_i,
   input  logic [2:0]         pix_row_i,
   input  logic [2:0]         pix_col_i,
   input  logic [1:0]         pix_color_i,
   input  logic               row_we_i,
   input  logic [2:0]         row_sel_i,
   input  logic [15:0]        row_data_i,
   output logic [FRAME_W-1:0] data_o
);

   logic [FRAME_W-1:0] data_q, data_d;
   logic [6:0]         pix_idx;
   logic [6:0]         row_idx;

   assign pix_idx = pix_lsb(pix_row_i, pix_col_i);
   // Row r covers bits [127-16r : 112-16r].
   assign row_idx = 7'd112 - {row_sel_i, 4'b0000};

   always_comb begin
      data_d = data_q;
      if (pix_we_i) begin
         if (pix_toggle_i) begin
            data_d[pix_idx +: 2] = data_q[pix_idx +: 2] ^ pix_color_i;
         end else begin
            data_d[pix_idx +: 2] = pix_color_i;
         end
      end
      if (row_we_i) begin
         data_d[row_idx +: 16] = row_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/matrix_frame_writer.sv
// -----------------------------------------------------------------------------
// matrix_frame_writer
// Producer side of the 8x8 red/green dot-matrix display. Takes WRITE, TOGGLE,
// FILL and SWAP commands, draws into a back buffer and copies it to the front
// buffer (frameO) only on the scanner's frame-start pulse, so the display
// never shows a half-drawn frame.
//
// Handshake: a command transfers on a rising clkI edge where validI && readyO.
// The issuer holds opI/rowI/colI/colorI stable while validI is high and
// readyO is low. readyO depends only on the FSM state and rstI, never on
// validI.
//
// Ports:
//   clkI, rstI       clock, synchronous active-high reset
//   validI, readyO   command handshake
//   opI              00 WRITE, 01 TOGGLE, 10 FILL, 11 SWAP
//   rowI, colI       pixel coordinates (ignored by FILL and SWAP)
//   colorI           bit1 = red, bit0 = green
//   frameSyncI       one-cycle frame-start pulse from the scanner
//   frameO           front buffer, pixel p at bits [127-2p : 126-2p]
//   swapDoneO        one-cycle pulse in the cycle frameO takes new contents
//   stateO           FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module matrix_frame_writer
   import matrix_pkg::*;
(
   input  logic               clkI,
   input  logic               rstI,
   input  logic               validI,
   output logic               readyO,
   input  logic [1:0]         opI,
   input  logic [2:0]         rowI,
   input  logic [2:0]         colI,
   input  logic [1:0]         colorI,
   input  logic               frameSyncI,
   output logic [FRAME_W-1:0] frameO,
   output logic               swapDoneO,
   output logic [1:0]         stateO
);

   state_e             state_q, state_d;
   logic [2:0]         fill_row_q, fill_row_d;
   logic [1:0]         fill_color_q, fill_color_d;
   logic [FRAME_W-1:0] front_q, front_d;
   logic               swap_done_q, swap_done_d;

   logic               accept;
   logic               pix_we;
   logic               pix_toggle;
   logic               row_we;
   logic [FRAME_W-1:0] back_data;

   assign readyO = (state_q == S_IDLE) && !rstI;
   assign accept = validI && readyO;

   always_comb begin
      state_d      = state_q;
      fill_row_d   = fill_row_q;
      fill_color_d = fill_color_q;
      front_d      = front_q;
      swap_done_d  = 1'b0;
      pix_we       = 1'b0;
      pix_toggle   = 1'b0;
      row_we       = 1'b0;

      case (state_q)
         S_IDLE: begin
            // frameSyncI is ignored here, which also covers a sync arriving
            // in the same cycle that a SWAP is accepted.
            if (accept) begin
               case (op_e'(opI))
                  OP_WRITE: begin
                     pix_we = 1'b1;
                  end
                  OP_TOGGLE: begin
                     pix_we     = 1'b1;
                     pix_toggle = 1'b1;
                  end
                  OP_FILL: begin
                     fill_color_d = colorI;
                     fill_row_d   = 3'd0;
                     state_d      = S_FILL;
                  end
                  OP_SWAP: begin
                     state_d = S_SWAP_WAIT;
                  end
                  default: ;
               endcase
            end
         end
         S_FILL: begin
            row_we     = 1'b1;
            fill_row_d = fill_row_q + 3'd1;
            if (fill_row_q == 3'd7) begin
               state_d = S_IDLE;
            end
         end
         S_SWAP_WAIT: begin
            if (frameSyncI) begin
               front_d     = back_data;
               swap_done_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clkI) begin
      if (rstI) begin
         state_q      <= S_IDLE;
         fill_row_q   <= 3'd0;
         fill_color_q <= C_OFF;
         front_q      <= '0;
         swap_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fill_row_q   <= fill_row_d;
         fill_color_q <= fill_color_d;
         front_q      <= front_d;
         swap_done_q  <= swap_done_d;
      end
   end

   matrix_bank u_bank (
      .clk_i        (clkI),
      .rst_i        (rstI),
      .pix_we_i     (pix_we),
      .pix_toggle_i (pix_toggle),
      .pix_row_i    (rowI),
      .pix_col_i    (colI),
      .pix_color_i  (colorI),
      .row_we_i     (row_we),
      .row_sel_i    (fill_row_q),
      .row_data_i   ({8{fill_color_q}}),
      .data_o       (back_data)
   );

   assign frameO    = front_q;
   assign swapDoneO = swap_done_q;
   assign stateO    = state_q;

endmodule

// File: tb/tb_matrix_frame_writer.sv
module tb_matrix_frame_writer;
   import matrix_pkg::*;

   logic         clkI = 1'b0;
   logic         rstI = 1'b1;
   logic         validI = 1'b0;
   logic         readyO;
   logic [1:0]   opI = 2'b00;
   logic [2:0]   rowI = 3'd0;
   logic [2:0]   colI = 3'd0;
   logic [1:0]   colorI = 2'b00;
   logic         frameSyncI = 1'b0;
   logic [127:0] frameO;
   logic         swapDoneO;
   logic [1:0]   stateO;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: one 2-bit colour per pixel, index p = row*8+col.
   logic [1:0] back_m [64];
   logic [1:0] front_m[64];

   matrix_frame_writer dut (
      .clkI       (clkI),
      .rstI       (rstI),
      .validI     (validI),
      .readyO     (readyO),
      .opI        (opI),
      .rowI       (rowI),
      .colI       (colI),
      .colorI     (colorI),
      .frameSyncI (frameSyncI),
      .frameO     (frameO),
      .swapDoneO  (swapDoneO),
      .stateO     (stateO)
   );

   // clock
   always #5 clkI = ~clkI;

   function automatic logic [127:0] model_frame();
      logic [127:0] f;
      f = '0;
      for (int p = 0; p < 64; p++) f[127-2*p -: 2] = front_m[p];
      return f;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkI);
      #1;
   endtask

   task automatic model_clear();
      for (int p = 0; p < 64; p++) begin
         back_m[p]  = 2'b00;
         front_m[p] = 2'b00;
      end
   endtask

   // Drive one command and hold it until accepted; update the model at the
   // accepting edge. Returns 1 ns after that edge with validI dropped.
   task automatic issue(input logic [1:0] op, input logic [2:0] r, input logic [2:0] c,
                        input logic [1:0] col, input logic sync);
      int waited;
      int p;
      waited = 0;
      validI = 1'b1; opI = op; rowI = r; colI = c; colorI = col; frameSyncI = sync;
      while (!readyO && waited < 40) begin
         tick();
         waited++;
      end
      if (!readyO) begin
         check("ready_timeout", readyO, 1'b1);
         validI = 1'b0; frameSyncI = 1'b0;
         return;
      end
      tick();
      validI = 1'b0; frameSyncI = 1'b0;
      p = r * 8 + c;
      case (op)
         2'b00: back_m[p] = col;
         2'b01: back_m[p] = back_m[p] ^ col;
         2'b10: for (int q = 0; q < 64; q++) back_m[q] = col;
         default: ;
      endcase
   endtask

   // Pulse frameSyncI while a swap is pending and check the swap outcome.
   task automatic sync_swap(input string tag);
      frameSyncI = 1'b1;
      tick();
      frameSyncI = 1'b0;
      for (int p = 0; p < 64; p++) front_m[p] = back_m[p];
      check({tag, "_done"}, swapDoneO, 1'b1);
      check({tag, "_frame"}, frameO, model_frame());
      check({tag, "_ready"}, readyO, 1'b1);
      tick();
      check({tag, "_done_low"}, swapDoneO, 1'b0);
   endtask

   initial begin
      int n;
      logic [1:0] exp_pix;
      model_clear();

      // ---- reset ----
      rstI = 1'b1;
      repeat (3) tick();
      check("rst_ready", readyO, 1'b0);
      check("rst_frame", frameO, '0);
      check("rst_done", swapDoneO, 1'b0);
      rstI = 1'b0;
      #1;
      check("post_rst_ready", readyO, 1'b1);
      check("post_rst_state", stateO, S_IDLE);

      // ---- WRITE (0,0,red), swap ----
      issue(OP_WRITE, 3'd0, 3'd0, C_RED, 1'b0);
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b0);
      check("swap_wait_state", stateO, S_SWAP_WAIT);
      check("swap_wait_done", swapDoneO, 1'b0);
      sync_swap("t1");
      exp_pix = C_RED;
      check("t1_pix00", frameO[127:126], exp_pix);
      check("t1_rest", frameO[125:0], '0);

      // ---- back-to-back writes ----
      issue(OP_WRITE, 3'd7, 3'd7, C_GREEN, 1'b0);
      check("b2b_ready", readyO, 1'b1);
      issue(OP_WRITE, 3'd3, 3'd4, C_AMBER, 1'b0);
      check("b2b_ready2", readyO, 1'b1);
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b0);
      sync_swap("t2");
      exp_pix = C_GREEN;
      check("t2_pix77", frameO[1:0], exp_pix);
      exp_pix = C_AMBER;
      check("t2_pix34", frameO[127-2*28 -: 2], exp_pix);

      // ---- FILL amber, ready low exactly 8 cycles ----
      issue(OP_FILL, 3'd5, 3'd2, C_AMBER, 1'b0);
      n = 0;
      while (!readyO && n < 20) begin
         n++;
         tick();
      end
      check("fill_busy_cycles", n, 8);
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b0);
      sync_swap("t3");
      check("t3_all_ones", frameO, {128{1'b1}});
      issue(OP_TOGGLE, 3'd2, 3'd5, C_RED, 1'b0);
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b0);
      sync_swap("t3b");
      exp_pix = C_GREEN;
      check("t3b_pix25", frameO[127-2*21 -: 2], exp_pix);

      // ---- SWAP accepted together with a sync pulse ----
      issue(OP_WRITE, 3'd5, 3'd5, C_OFF, 1'b0);
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b1);
      check("samecyc_frame", frameO, model_frame());
      check("samecyc_done", swapDoneO, 1'b0);
      repeat (19) tick();
      check("samecyc_still_wait", stateO, S_SWAP_WAIT);
      check("samecyc_frame_hold", frameO, model_frame());
      sync_swap("t4");

      // ---- reset mid-FILL (row 4 in progress) ----
      issue(OP_FILL, 3'd0, 3'd0, C_GREEN, 1'b0);
      repeat (4) tick();
      check("midfill_state", stateO, S_FILL);
      rstI = 1'b1;
      #1;
      check("midfill_rst_ready", readyO, 1'b0);
      tick();
      rstI = 1'b0;
      #1;
      model_clear();
      check("midfill_frame", frameO, '0);
      check("midfill_state_idle", stateO, S_IDLE);
      check("midfill_ready", readyO, 1'b1);

      // ---- reset during SWAP_WAIT ----
      issue(OP_WRITE, 3'd1, 3'd6, C_RED, 1'b0);
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b0);
      rstI = 1'b1;
      tick();
      rstI = 1'b0;
      #1;
      model_clear();
      check("midswap_ready", readyO, 1'b1);
      check("midswap_state", stateO, S_IDLE);
      frameSyncI = 1'b1;
      tick();
      frameSyncI = 1'b0;
      check("midswap_no_done", swapDoneO, 1'b0);
      check("midswap_frame", frameO, '0);
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b0);
      sync_swap("t5_back_cleared");

      // ---- command held during FILL lands once ----
      issue(OP_FILL, 3'd0, 3'd0, C_GREEN, 1'b0);
      issue(OP_WRITE, 3'd1, 3'd1, C_RED, 1'b0);
      issue(OP_FILL, 3'd0, 3'd0, C_AMBER, 1'b0);
      issue(OP_TOGGLE, 3'd6, 3'd0, C_RED, 1'b0);
      check("held_ready_after", readyO, 1'b1);
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b0);
      sync_swap("t6");
      exp_pix = C_GREEN;
      check("t6_toggle_once", frameO[127-2*48 -: 2], exp_pix);

      // ---- randomized commands against the model ----
      for (int i = 0; i < 200; i++) begin
         int k;
         k = $urandom_range(0, 19);
         if (k < 8) begin
            issue(OP_WRITE, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end else if (k < 16) begin
            issue(OP_TOGGLE, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end else if (k == 16) begin
            issue(OP_FILL, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end else begin
            issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
            sync_swap("rnd_swap");
         end
         check("rnd_frame", frameO, model_frame());
      end
      issue(OP_SWAP, 3'd0, 3'd0, C_OFF, 1'b0);
      sync_swap("rnd_final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
